// File: rtl/bus_pkg.sv
// Shared CPU bus definitions: cartridge address map, open-bus value,
// bridge FSM states and the cartridge range decode reused by other bus stages.
package bus_pkg;

  localparam logic [15:0] CART_ROM_LO = 16'h0000;
  localparam logic [15:0] CART_ROM_HI = 16'h7fff;
  localparam logic [15:0] CART_RAM_LO = 16'ha000;
  localparam logic [15:0] CART_RAM_HI = 16'hbfff;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hff;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  // Offset compare keeps the decode free of always-true bounds when a range starts at 0.
  function automatic logic in_range(input logic [15:0] addr);
    logic [15:0] rom_off;
    logic [15:0] ram_off;
    rom_off = addr - CART_ROM_LO;
    ram_off = addr - CART_RAM_LO;
    return (rom_off <= (CART_ROM_HI - CART_ROM_LO)) ||
           (ram_off <= (CART_RAM_HI - CART_RAM_LO));
  endfunction

endpackage

// File: rtl/cart_bus_bridge_if.sv
// External cartridge memory port: req/ack handshake with latched address and data.
interface cart_bus_bridge_if;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cart_bus_bridge.sv
// Forwards unclaimed CPU loads/stores to the cartridge port and merges
// boot overlay and cartridge read data onto one CPU read path.
//
// state | meaning
// IDLE  | waiting for a qualifying CPU strobe
// REQ   | mem_req held, waiting for mem_ack or timeout
// RESP  | data_valid pulse with captured data (held while boot_active)
module cart_bus_bridge
  import bus_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [15:0] BOOT_END = 16'h00ff,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic                      clockgb,
  input  logic                      reset,
  input  logic [15:0]               address,
  input  logic [7:0]                indata,
  input  logic                      load,
  input  logic                      store,
  input  logic                      boot_map,
  input  logic                      boot_active,
  input  logic [7:0]                boot_outdata,
  output logic [7:0]                outdata,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      timeout_err,
  cart_bus_bridge_if.master         mem
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [7:0]    rsp_data;
  logic          boot_claim;
  logic          start;

  always_comb begin
    boot_claim = load && !store && boot_map && (address <= BOOT_END);
    start      = (store || (load && !boot_claim)) && in_range(address);
  end

  always_ff @(posedge clockgb) begin
    if (reset) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      tmo_cnt       <= '0;
      rsp_data      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= store;
            mem.mem_addr  <= address;
            mem.mem_wdata <= indata;
            tmo_cnt       <= CW'(TIMEOUT - 1);
            state         <= REQ;
          end
        end
        REQ: begin
          // An ack on the terminal-count cycle wins over the timeout.
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            rsp_data    <= mem.mem_we ? 8'h00 : mem.mem_rdata;
            state       <= RESP;
          end else if (tmo_cnt == '0) begin
            mem.mem_req <= 1'b0;
            timeout_err <= 1'b1;
            rsp_data    <= mem.mem_we ? 8'h00 : OPEN_BUS;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        RESP: begin
          if (!boot_active) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    data_valid = boot_active || (state == RESP);
    if (boot_active)         outdata = boot_outdata;
    else if (state == RESP)  outdata = rsp_data;
    else                     outdata = 8'h00;
  end

endmodule

// File: tb/tb_cart_bus_bridge.sv
// Self-checking bench for cart_bus_bridge: directed scenarios plus random
// transactions checked against a transaction-level model of the bus rules.
module tb_cart_bus_bridge;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  indata;
  logic        load;
  logic        store;
  logic        boot_map;
  logic        boot_active;
  logic [7:0]  boot_outdata;
  logic [7:0]  outdata;
  logic        data_valid;
  logic        busy;
  logic        timeout_err;

  cart_bus_bridge_if mem();

  cart_bus_bridge #(.TIMEOUT(TMO)) dut (
    .clockgb      (clk),
    .reset        (reset),
    .address      (address),
    .indata       (indata),
    .load         (load),
    .store        (store),
    .boot_map     (boot_map),
    .boot_active  (boot_active),
    .boot_outdata (boot_outdata),
    .outdata      (outdata),
    .data_valid   (data_valid),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .mem          (mem.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit terr_m     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cart_addr(input logic [15:0] a);
    return (a <= 16'h7fff) || (a >= 16'ha000 && a <= 16'hbfff);
  endfunction

  // One CPU strobe in cycle 0, then eight observed cycles. dly = cycles after
  // the first request cycle at which memory acks; dly >= TMO means too late.
  task automatic run_txn(input string tag, input logic [15:0] a, input logic [7:0] wd,
                         input logic ld, input logic st, input logic bm, input int dly,
                         input logic [7:0] rd, input logic [7:0] bd, input bit poke);
    int          kind;
    int          exp_vc;
    int          exp_reqc;
    logic [7:0]  exp_od;
    int          vc;
    int          vcount;
    int          reqc;
    logic [7:0]  od;
    logic [15:0] ma;
    logic        mwe;
    logic [7:0]  mwd;
    bit          seen;

    if (st)      kind = cart_addr(a) ? 3 : 0;
    else if (ld) kind = (bm && a <= 16'h00ff) ? 1 : (cart_addr(a) ? 2 : 0);
    else         kind = 0;

    exp_vc = 0; exp_reqc = 0; exp_od = 8'h00;
    if (kind == 1) begin
      exp_vc = 2; exp_od = bd;
    end else if (kind >= 2) begin
      if (dly < TMO) begin
        exp_vc   = 2 + dly;
        exp_reqc = dly + 1;
        exp_od   = (kind == 2) ? rd : 8'h00;
      end else begin
        exp_vc   = TMO + 1;
        exp_reqc = TMO;
        exp_od   = (kind == 2) ? 8'hff : 8'h00;
        terr_m   = 1'b1;
      end
    end

    vc = 0; vcount = 0; reqc = 0; od = 8'h00; ma = '0; mwe = 1'b0; mwd = '0; seen = 1'b0;

    @(posedge clk); #1;
    address = a; indata = wd; load = ld; store = st; boot_map = bm;
    mem.mem_ack = 1'b0; boot_active = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      load = 1'b0; store = 1'b0;
      if (poke && c == 1) begin
        load = 1'b1; address = 16'h7fff; indata = 8'($urandom);
      end
      mem.mem_ack   = (kind >= 2) && (c == 1 + dly);
      mem.mem_rdata = mem.mem_ack ? rd : 8'($urandom);
      boot_active   = (kind == 1) && (c == 2);
      boot_outdata  = boot_active ? bd : 8'($urandom);
      #1;
      if (mem.mem_req) begin
        reqc++;
        if (!seen) begin
          seen = 1'b1; ma = mem.mem_addr; mwe = mem.mem_we; mwd = mem.mem_wdata;
        end
      end
      if (data_valid) begin
        vcount++; vc = c; od = outdata;
      end
    end
    mem.mem_ack = 1'b0; boot_active = 1'b0;

    chk({tag, "_valid_count"}, 32'(vcount), 32'((kind != 0) ? 1 : 0));
    chk({tag, "_valid_cycle"}, 32'(vc), 32'(exp_vc));
    chk({tag, "_outdata"}, 32'(od), 32'(exp_od));
    chk({tag, "_req_cycles"}, 32'(reqc), 32'(exp_reqc));
    if (kind >= 2) begin
      chk({tag, "_mem_addr"}, 32'(ma), 32'(a));
      chk({tag, "_mem_we"}, 32'(mwe), 32'(kind == 3));
      if (kind == 3) chk({tag, "_mem_wdata"}, 32'(mwd), 32'(wd));
    end
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(terr_m));
    chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int          vcnt;
    logic [15:0] ra;
    logic        rl;
    logic        rs;
    int          mode;

    reset = 1'b1; address = '0; indata = '0; load = 1'b0; store = 1'b0;
    boot_map = 1'b0; boot_active = 1'b0; boot_outdata = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outdata", 32'(outdata), 32'(0));
    chk("rst_data_valid", 32'(data_valid), 32'(0));
    chk("rst_mem_req", 32'(mem.mem_req), 32'(0));
    chk("rst_mem_we", 32'(mem.mem_we), 32'(0));
    chk("rst_mem_addr", 32'(mem.mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem.mem_wdata), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    reset = 1'b0;

    run_txn("t1_boot_read", 16'h0042, 8'h00, 1'b1, 1'b0, 1'b1, 0, 8'h00, 8'h31, 1'b0);
    run_txn("t2_cart_read", 16'h0042, 8'h00, 1'b1, 1'b0, 1'b0, 2, 8'h5a, 8'h00, 1'b0);
    run_txn("t3_mbc_write", 16'h2000, 8'h01, 1'b0, 1'b1, 1'b1, 1, 8'h00, 8'h00, 1'b0);
    run_txn("t_fast_ack", 16'hb000, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'hc3, 8'h00, 1'b0);
    run_txn("t_last_cycle_ack", 16'h1111, 8'h00, 1'b1, 1'b0, 1'b0, TMO - 1, 8'h9e, 8'h00, 1'b0);
    run_txn("t4_timeout", 16'ha123, 8'h00, 1'b1, 1'b0, 1'b0, 99, 8'h00, 8'h00, 1'b0);
    run_txn("t4_after_timeout", 16'h0100, 8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h3c, 8'h00, 1'b0);
    run_txn("t5_load_store", 16'h4000, 8'h88, 1'b1, 1'b1, 1'b0, 1, 8'h55, 8'h00, 1'b0);
    run_txn("t5_busy_drop", 16'h0200, 8'h00, 1'b1, 1'b0, 1'b0, 2, 8'h66, 8'h00, 1'b1);
    run_txn("t5_unmapped", 16'hc000, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h12, 8'h00, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'($urandom_range(0, 16'h00ff));
        1:       ra = 16'($urandom_range(0, 16'h7fff));
        2:       ra = 16'($urandom_range(16'ha000, 16'hbfff));
        default: ra = 16'($urandom_range(16'h8000, 16'hffff));
      endcase
      mode = $urandom_range(0, 3);
      rl = (mode != 1);
      rs = (mode == 1) || (mode == 2);
      run_txn("rnd", ra, 8'($urandom), rl, rs, 1'($urandom_range(0, 1)),
              $urandom_range(0, 5), 8'($urandom), 8'($urandom), 1'b0);
    end

    // Reset while a request is outstanding.
    @(posedge clk); #1;
    address = 16'h1234; load = 1'b1; boot_map = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; #1;
    chk("t6_req_up", 32'(mem.mem_req), 32'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    terr_m = 1'b0;
    chk("t6_req_dropped", 32'(mem.mem_req), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem.mem_ack   = (c == 0);
      mem.mem_rdata = 8'h77;
      #1;
      if (data_valid) vcnt++;
    end
    mem.mem_ack = 1'b0;
    chk("t6_late_ack_valid", 32'(vcnt), 32'(0));
    chk("t6_outdata", 32'(outdata), 32'(0));
    chk("t6_mem_req", 32'(mem.mem_req), 32'(0));
    chk("t6_mem_we", 32'(mem.mem_we), 32'(0));
    chk("t6_mem_addr", 32'(mem.mem_addr), 32'(0));
    chk("t6_mem_wdata", 32'(mem.mem_wdata), 32'(0));
    chk("t6_timeout_err", 32'(timeout_err), 32'(terr_m));
    chk("t6_busy_end", 32'(busy), 32'(0));

    run_txn("t6_after_reset", 16'h0300, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'ha5, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
